// File: rtl/crc_pkg.sv
// Shared types, presets and combinational helpers for the parallel CRC engine.
package crc_pkg;

  localparam int MAX_CRC_W  = 32;
  localparam int MAX_DATA_W = 64;

  typedef enum logic {GEN = 1'b0, CHECK = 1'b1} mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_ACCUM = 1'b1} state_e;

  typedef struct packed {
    logic [31:0] poly;
    logic [31:0] init;
    logic [31:0] xor_out;
    logic [5:0]  width;
    logic        reflect;
  } crc_preset_t;

  localparam crc_preset_t CRC16_CCITT_FALSE = '{poly: 32'h0000_1021, init: 32'h0000_FFFF,
                                                xor_out: 32'h0000_0000, width: 6'd16, reflect: 1'b0};
  localparam crc_preset_t CRC32_ETH         = '{poly: 32'h04C1_1DB7, init: 32'hFFFF_FFFF,
                                                xor_out: 32'hFFFF_FFFF, width: 6'd32, reflect: 1'b1};
  localparam crc_preset_t CRC5_USB          = '{poly: 32'h0000_0005, init: 32'h0000_001F,
                                                xor_out: 32'h0000_001F, width: 6'd5, reflect: 1'b1};

  // Mask of the low w bits (w in 1..32).
  function automatic logic [31:0] width_mask(input int w);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < MAX_CRC_W; i++) begin
      if (i < w) m[i] = 1'b1;
    end
    return m;
  endfunction

  // Reverse the low w bits of x; bits above w come back as zero.
  function automatic logic [63:0] bit_rev(input logic [63:0] x, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < w) r[i] = x[w-1-i];
    end
    return r;
  endfunction

  // One whole beat through a crc_w-bit LFSR, data MSB (bit data_w-1) first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [63:0] data,
                                           input logic [31:0] poly, input int crc_w,
                                           input int data_w);
    logic [31:0] c;
    logic [31:0] mask;
    logic        fb;
    mask = width_mask(crc_w);
    c    = crc & mask;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      if (i < data_w) begin
        fb = c[crc_w-1] ^ data[data_w-1-i];
        c  = {c[30:0], 1'b0};
        if (fb) c = c ^ poly;
        c  = c & mask;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_out_reg.sv
// One-entry valid/ready holding stage for the per-packet CRC result.
module crc_out_reg
  import crc_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_crc,
  input  logic         load_err,
  input  logic         pop,
  output logic         out_valid,
  output logic [W-1:0] out_crc,
  output logic         out_err
);

  logic         valid_q, valid_d;
  logic [W-1:0] crc_q, crc_d;
  logic         err_q, err_d;

  // A load always wins (covers pop+load in the same cycle); a bare pop empties the slot.
  always_comb begin
    valid_d = valid_q;
    crc_d   = crc_q;
    err_d   = err_q;
    if (load) begin
      valid_d = 1'b1;
      crc_d   = load_crc;
      err_d   = load_err;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  // Holding register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      crc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      crc_q   <= crc_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_crc   = crc_q;
  assign out_err   = err_q;

endmodule

// File: rtl/crc_stream_par.sv
// Streaming parallel CRC: one DATA_W-bit beat per cycle, per-packet result with optional check.
module crc_stream_par
  import crc_pkg::*;
#(
  parameter int          DATA_W      = 8,
  parameter int          CRC_W       = 16,
  parameter logic [31:0] POLY        = 32'h0000_1021,
  parameter logic [31:0] INIT        = 32'h0000_FFFF,
  parameter logic [31:0] XOR_OUT     = 32'h0000_0000,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_check,
  input  logic [CRC_W-1:0]  exp_crc,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_W-1:0]  out_crc,
  output logic              out_err
);

  localparam logic [CRC_W-1:0] POLY_T = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_T = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_T  = XOR_OUT[CRC_W-1:0];

  state_e           state_q, state_d;
  logic [CRC_W-1:0] crc_q, crc_d;
  logic [63:0]      beat;
  logic [CRC_W-1:0] crc_src;
  logic [CRC_W-1:0] next_crc;
  logic [CRC_W-1:0] final_crc;
  logic             final_err;
  logic             accept;
  logic             load;
  mode_e            mode;

  // The only stall is a held, unconsumed result; nothing is accepted during reset.
  assign in_ready = !rst && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign mode     = mode_e'(mode_check);

  // Beat datapath: a fresh packet starts from INIT without waiting for crc_q to be reloaded.
  always_comb begin
    beat      = REFLECT_IN ? bit_rev(64'(in_data), DATA_W) : 64'(in_data);
    crc_src   = (state_q == ST_IDLE) ? INIT_T : crc_q;
    next_crc  = CRC_W'(crc_step(32'(crc_src), beat, 32'(POLY_T), CRC_W, DATA_W));
    final_crc = (REFLECT_OUT ? CRC_W'(bit_rev(64'(next_crc), CRC_W)) : next_crc) ^ XOR_T;
    final_err = (mode == CHECK) && (final_crc != exp_crc);
  end

  // Packet FSM: accumulate on non-last beats, hand off and rearm on the last beat.
  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    load    = 1'b0;
    if (accept) begin
      if (in_last) begin
        load    = 1'b1;
        state_d = ST_IDLE;
        crc_d   = INIT_T;
      end else begin
        state_d = ST_ACCUM;
        crc_d   = next_crc;
      end
    end
  end

  // Running CRC and packet state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      crc_q   <= INIT_T;
    end else begin
      state_q <= state_d;
      crc_q   <= crc_d;
    end
  end

  crc_out_reg #(.W(CRC_W)) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_crc  (final_crc),
    .load_err  (final_err),
    .pop       (out_ready),
    .out_valid (out_valid),
    .out_crc   (out_crc),
    .out_err   (out_err)
  );

endmodule

// File: tb/tb_crc_stream_par.sv
// Bench for crc_stream_par: CRC-16/CCITT-FALSE instance plus a CRC-32 (Ethernet) instance.
module tb_crc_stream_par;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Instance A: default CRC-16 settings.
  logic        d_in_valid = 0, d_in_last = 0, d_mode = 0, d_out_ready = 1;
  logic [7:0]  d_in_data = 0;
  logic [15:0] d_exp = 0;
  logic        d_in_ready, d_out_valid, d_out_err;
  logic [15:0] d_out_crc;

  // Instance B: reflected CRC-32.
  logic        e_in_valid = 0, e_in_last = 0, e_mode = 0, e_out_ready = 1;
  logic [7:0]  e_in_data = 0;
  logic [31:0] e_exp = 0;
  logic        e_in_ready, e_out_valid, e_out_err;
  logic [31:0] e_out_crc;

  crc_stream_par dut_a (
    .clk(clk), .rst(rst), .mode_check(d_mode), .exp_crc(d_exp),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .in_data(d_in_data), .in_last(d_in_last),
    .out_valid(d_out_valid), .out_ready(d_out_ready), .out_crc(d_out_crc), .out_err(d_out_err)
  );

  crc_stream_par #(
    .DATA_W(8), .CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF),
    .XOR_OUT(32'hFFFFFFFF), .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .mode_check(e_mode), .exp_crc(e_exp),
    .in_valid(e_in_valid), .in_ready(e_in_ready), .in_data(e_in_data), .in_last(e_in_last),
    .out_valid(e_out_valid), .out_ready(e_out_ready), .out_crc(e_out_crc), .out_err(e_out_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int timeouts = 0;
  bit rand_ready = 0;
  bit watch_valid = 0;
  int valid_low_cnt = 0;

  logic [16:0] got_a[$], exp_a[$];   // {err, crc}
  logic [32:0] got_b[$], exp_b[$];
  byte unsigned cur_a[$], cur_b[$];
  byte unsigned str[$];

  // Reference CRC-16/CCITT-FALSE: byte-wise XOR into the top, shift left.
  function automatic logic [15:0] model16(input byte unsigned m[$]);
    logic [15:0] c = 16'hFFFF;
    foreach (m[k]) begin
      c = c ^ {m[k], 8'h00};
      repeat (8) c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // Reference CRC-32: classic reflected right-shift form with the reversed polynomial.
  function automatic logic [31:0] model32(input byte unsigned m[$]);
    logic [31:0] c = 32'hFFFFFFFF;
    foreach (m[k]) begin
      c = c ^ {24'h0, m[k]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  // Result monitor: records every consumed output.
  always @(negedge clk) begin
    if (!rst) begin
      if (d_out_valid && d_out_ready) got_a.push_back({d_out_err, d_out_crc});
      if (e_out_valid && e_out_ready) got_b.push_back({e_out_err, e_out_crc});
      if (watch_valid && !d_out_valid) valid_low_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) d_out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic idle(input int n);
    d_in_valid = 0;
    e_in_valid = 0;
    repeat (n) tick();
  endtask

  task automatic clear_queues();
    got_a.delete(); exp_a.delete(); got_b.delete(); exp_b.delete();
    cur_a.delete(); cur_b.delete();
  endtask

  // Present one beat and hold it until accepted; records the expected result on a last beat.
  task automatic send_beat(input int sel, input logic [7:0] data, input bit last,
                           input bit mode, input logic [31:0] expv);
    logic acc = 1'b0;
    logic [15:0] c16;
    logic [31:0] c32;
    if (sel == 0) begin
      d_in_valid = 1; d_in_data = data; d_in_last = last; d_mode = mode; d_exp = expv[15:0];
    end else begin
      e_in_valid = 1; e_in_data = data; e_in_last = last; e_mode = mode; e_exp = expv;
    end
    for (int t = 0; t < 300 && !acc; t++) begin
      @(negedge clk);
      acc = (sel == 0) ? d_in_ready : e_in_ready;
      tick();
    end
    if (!acc) begin
      timeouts++;
      return;
    end
    if (sel == 0) begin
      cur_a.push_back(data);
      if (last) begin
        c16 = model16(cur_a);
        exp_a.push_back({mode && (c16 != expv[15:0]), c16});
        cur_a.delete();
      end
    end else begin
      cur_b.push_back(data);
      if (last) begin
        c32 = model32(cur_b);
        exp_b.push_back({mode && (c32 != expv), c32});
        cur_b.delete();
      end
    end
  endtask

  task automatic send_pkt(input int sel, input byte unsigned m[$], input bit mode,
                          input logic [31:0] expv);
    foreach (m[k]) send_beat(sel, m[k], k == m.size() - 1, mode, expv);
    d_in_valid = 0;
    e_in_valid = 0;
  endtask

  task automatic wait_results(input int sel, input int n);
    for (int t = 0; t < 400; t++) begin
      if (((sel == 0) ? got_a.size() : got_b.size()) >= n) break;
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (d_in_ready !== 1'b0) begin n_bad++; $display("FAIL reset_in_ready got %b want 0", d_in_ready); end
    n_cmp++; if (d_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid got %b want 0", d_out_valid); end
    n_cmp++; if (d_out_crc !== 16'h0) begin n_bad++; $display("FAIL reset_out_crc got %h want 0000", d_out_crc); end
    n_cmp++; if (d_out_err !== 1'b0) begin n_bad++; $display("FAIL reset_out_err got %b want 0", d_out_err); end
    n_cmp++; if (e_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_out_valid got %b want 0", e_out_valid); end
    @(posedge clk); #1;
    rst = 0;
    tick();
    @(negedge clk);
    n_cmp++; if (d_in_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_in_ready got %b want 1", d_in_ready); end
    tick();
    $display("reset: done");
  endtask

  task automatic test_gen_string();
    clear_queues();
    send_pkt(0, str, 0, 0);
    wait_results(0, 1);
    n_cmp++; if (got_a.size() != 1) begin n_bad++; $display("FAIL gen_count got %0d want 1", got_a.size()); end
    else begin
      n_cmp++; if (got_a[0] !== {1'b0, 16'h29B1}) begin n_bad++; $display("FAIL gen_123456789 got %h want 0_29b1", got_a[0]); end
    end
    $display("gen \"123456789\": crc=%h", d_out_crc);
  endtask

  task automatic test_single_beat();
    int cnt = 0;
    clear_queues();
    send_beat(0, 8'h00, 1, 0, 0);
    d_in_valid = 0;
    @(negedge clk);
    n_cmp++; if (d_out_valid !== 1'b1) begin n_bad++; $display("FAIL single_latency out_valid got %b want 1", d_out_valid); end
    n_cmp++; if (d_out_crc !== 16'hE1F0) begin n_bad++; $display("FAIL single_crc got %h want e1f0", d_out_crc); end
    cnt += int'(d_out_valid);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      cnt += int'(d_out_valid);
    end
    tick();
    n_cmp++; if (cnt != 1) begin n_bad++; $display("FAIL single_valid_cycles got %0d want 1", cnt); end
    $display("single beat 00: crc=%h valid_cycles=%0d", d_out_crc, cnt);
  endtask

  task automatic test_crc32();
    clear_queues();
    send_pkt(1, str, 0, 0);
    wait_results(1, 1);
    n_cmp++; if (got_b.size() != 1) begin n_bad++; $display("FAIL crc32_count got %0d want 1", got_b.size()); end
    else begin
      n_cmp++; if (got_b[0] !== {1'b0, 32'hCBF43926}) begin n_bad++; $display("FAIL crc32_123456789 got %h want 0_cbf43926", got_b[0]); end
    end
    $display("crc32 \"123456789\": crc=%h", e_out_crc);
  endtask

  task automatic test_check_mode();
    clear_queues();
    send_pkt(0, str, 1, 32'h29B1);
    send_pkt(0, str, 1, 32'h29B0);
    wait_results(0, 2);
    n_cmp++; if (got_a.size() != 2) begin n_bad++; $display("FAIL check_count got %0d want 2", got_a.size()); end
    else begin
      n_cmp++; if (got_a[0] !== {1'b0, 16'h29B1}) begin n_bad++; $display("FAIL check_match got %h want 0_29b1", got_a[0]); end
      n_cmp++; if (got_a[1] !== {1'b1, 16'h29B1}) begin n_bad++; $display("FAIL check_mismatch got %h want 1_29b1", got_a[1]); end
    end
    $display("check mode: two packets, expected errs 0 then 1");
  endtask

  task automatic test_back_to_back();
    byte unsigned pa[$], pb[$];
    logic [15:0] ca;
    clear_queues();
    repeat (3) pa.push_back(8'($urandom));
    repeat (4) pb.push_back(8'($urandom));
    ca = model16(pa);
    d_out_ready = 0;
    send_pkt(0, pa, 0, 0);
    for (int i = 0; i < 5; i++) begin
      d_in_valid = 1; d_in_data = pb[0]; d_in_last = 0; d_mode = 0;
      @(negedge clk);
      n_cmp++; if (d_in_ready !== 1'b0) begin n_bad++; $display("FAIL held_in_ready cyc %0d got %b want 0", i, d_in_ready); end
      n_cmp++; if ({d_out_valid, d_out_crc} !== {1'b1, ca}) begin n_bad++; $display("FAIL held_result cyc %0d got %b/%h want 1/%h", i, d_out_valid, d_out_crc, ca); end
      tick();
    end
    d_out_ready = 1;
    send_pkt(0, pb, 0, 0);
    wait_results(0, 2);
    n_cmp++; if (got_a.size() != 2) begin n_bad++; $display("FAIL b2b_count got %0d want 2", got_a.size()); end
    else begin
      n_cmp++; if (got_a[0] !== {1'b0, ca}) begin n_bad++; $display("FAIL b2b_first got %h want %h", got_a[0], {1'b0, ca}); end
      n_cmp++; if (got_a[1] !== exp_a[1]) begin n_bad++; $display("FAIL b2b_second got %h want %h", got_a[1], exp_a[1]); end
    end
    // Consecutive single-beat packets with a free output must keep out_valid high.
    clear_queues();
    valid_low_cnt = 0;
    send_beat(0, 8'($urandom), 1, 0, 0);
    watch_valid = 1;
    for (int i = 0; i < 3; i++) send_beat(0, 8'($urandom), 1, 0, 0);
    watch_valid = 0;
    idle(0);
    wait_results(0, 4);
    n_cmp++; if (valid_low_cnt != 0) begin n_bad++; $display("FAIL no_bubble valid_low_cycles got %0d want 0", valid_low_cnt); end
    n_cmp++; if (got_a.size() != 4) begin n_bad++; $display("FAIL no_bubble_count got %0d want 4", got_a.size()); end
    else for (int k = 0; k < 4; k++) begin
      n_cmp++; if (got_a[k] !== exp_a[k]) begin n_bad++; $display("FAIL no_bubble_%0d got %h want %h", k, got_a[k], exp_a[k]); end
    end
    $display("back-to-back: held 5 cycles, then 4 single-beat packets");
  endtask

  task automatic test_reset_mid();
    clear_queues();
    // A pending result is dropped by reset.
    d_out_ready = 0;
    send_beat(0, 8'h5A, 1, 0, 0);
    d_in_valid = 0;
    rst = 1;
    @(negedge clk);
    n_cmp++; if (d_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_drops_pending got %b want 0", d_out_valid); end
    @(posedge clk); #1;
    rst = 0;
    d_out_ready = 1;
    clear_queues();
    tick();
    // A partial packet is discarded by reset.
    for (int k = 0; k < 4; k++) send_beat(0, str[k], 0, 0, 0);
    d_in_valid = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    clear_queues();
    tick();
    send_pkt(0, str, 0, 0);
    wait_results(0, 1);
    n_cmp++; if (got_a.size() != 1) begin n_bad++; $display("FAIL reset_mid_count got %0d want 1", got_a.size()); end
    else begin
      n_cmp++; if (got_a[0] !== {1'b0, 16'h29B1}) begin n_bad++; $display("FAIL reset_mid_crc got %h want 0_29b1", got_a[0]); end
    end
    $display("reset mid-packet: restart result crc=%h", d_out_crc);
  endtask

  task automatic test_random();
    byte unsigned m[$];
    logic [15:0] c;
    logic [15:0] ev;
    bit mode;
    clear_queues();
    rand_ready = 1;
    for (int p = 0; p < 25; p++) begin
      m.delete();
      repeat ($urandom_range(1, 5)) m.push_back(8'($urandom));
      c = model16(m);
      mode = 1'($urandom_range(0, 1));
      ev = ($urandom_range(0, 1) == 1) ? c : (c ^ 16'(1 << $urandom_range(0, 15)));
      for (int k = 0; k < m.size(); k++) begin
        send_beat(0, m[k], k == m.size() - 1, mode, {16'h0, ev});
        if (k != m.size() - 1 && $urandom_range(0, 3) == 0) begin
          d_in_valid = 0;
          repeat ($urandom_range(1, 3)) tick();
        end
      end
      d_in_valid = 0;
      repeat ($urandom_range(0, 2)) tick();
      $display("random pkt %0d: len=%0d mode=%0d exp_crc=%h model=%h", p, m.size(), mode, ev, c);
    end
    rand_ready = 0;
    d_out_ready = 1;
    wait_results(0, exp_a.size());
    n_cmp++; if (got_a.size() != exp_a.size()) begin n_bad++; $display("FAIL random_count got %0d want %0d", got_a.size(), exp_a.size()); end
    for (int k = 0; k < exp_a.size() && k < got_a.size(); k++) begin
      n_cmp++; if (got_a[k] !== exp_a[k]) begin n_bad++; $display("FAIL random_pkt_%0d got %h want %h", k, got_a[k], exp_a[k]); end
    end
  endtask

  initial begin
    for (int i = 0; i < 9; i++) str.push_back(8'h31 + 8'(i));
    test_reset();
    test_gen_string();
    test_single_beat();
    test_crc32();
    test_check_mode();
    test_back_to_back();
    test_reset_mid();
    test_random();
    n_cmp++; if (timeouts != 0) begin n_bad++; $display("FAIL handshake_timeouts got %0d want 0", timeouts); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/crc_stream_par.md
Name: crc_stream_par

Overview:
Parametrised parallel CRC engine, successor to the fixed 4-bit/CRC-5 parallel CRC block.
- Consumes a packet as a stream of DATA_W-bit beats under a valid/ready handshake.
- Computes any CRC_W-bit CRC defined by polynomial, init, reflect and xor-out settings.
- Presents the final CRC per packet on a buffered valid/ready output.
- Sits between packet framers and link-layer TX/RX checkers.
- CHECK mode compares the CRC against an expected value and flags a mismatch.

Parameters:
DATA_W, 8, beat width in bits (1..64)
CRC_W, 16, CRC width in bits (2..32)
POLY, 16'h1021, generator polynomial, implicit top bit omitted
INIT, 16'hFFFF, CRC register value at the start of each packet
XOR_OUT, 16'h0000, XORed into the final CRC
REFLECT_IN, 0, 1 = bit-reverse each beat before processing
REFLECT_OUT, 0, 1 = bit-reverse the CRC register before XOR_OUT

Ports:
clk  in  1  single clock, all logic on posedge
rst  in  1  reset, asynchronous, active-high
mode_check  in  1  sampled with the last beat: 0 = GEN, 1 = CHECK
exp_crc  in  CRC_W  expected CRC, sampled with the last beat when mode_check=1
in_valid  in  1  beat valid
in_ready  out  1  beat accepted when in_valid && in_ready
in_data  in  DATA_W  beat data, MSB-first unless REFLECT_IN
in_last  in  1  marks the final beat of the packet
out_valid  out  1  result available
out_ready  in  1  result consumed when out_valid && out_ready
out_crc  out  CRC_W  final CRC (after reflect and xor-out)
out_err  out  1  CHECK mode only: out_crc != exp_crc; 0 in GEN mode

Behaviour:
- Reset values: crc_q = INIT, state = IDLE, out_valid = 0, out_crc = 0, out_err = 0. in_ready = 0 while rst is asserted.
- States:
  - IDLE: no beats consumed yet for the current packet.
  - ACCUM: one or more beats consumed, in_last not yet seen.
  - Output register: a separate 1-entry holding stage, occupied when out_valid = 1.
- Ready rule: in_ready = !out_valid || out_ready. The engine always accepts beats while the output is free or draining; no other stall source exists.
- Per accepted beat: next = step(crc_src, beat). crc_src = INIT in IDLE, crc_q in ACCUM.
  - step is a pure combinational unrolled DATA_W-iteration LFSR, MSB-first.
  - The whole beat is processed in one cycle.
- Non-last beat: crc_q <= next, state -> ACCUM.
- Last beat: out_crc <= final(next), out_valid <= 1, and out_err is loaded at the same edge as out_crc:
  - GEN mode: out_err <= 0.
  - CHECK mode: out_err <= (final(next) != exp_crc).
  - Then crc_q <= INIT, state -> IDLE.
  - final(x) = (REFLECT_OUT ? rev(x) : x) ^ XOR_OUT.
- Latency: out_valid rises on the clock edge that accepts the last beat, i.e. visible the cycle after the handshake.
- Single-beat packet: a beat in IDLE with in_last = 1 goes IDLE->IDLE and the result equals final(step(INIT, beat)).
- Back-to-back packets: a last beat accepted in the same cycle as out_valid && out_ready overwrites the output with the new result; out_valid stays 1 with no bubble.
- Output held (out_valid = 1, out_ready = 0): in_ready = 0. crc_q, out_crc and out_err are stable until the output is taken.
- Output pops with no new last beat: out_valid <= 0; out_crc and out_err keep their old values (don't-care).
- in_valid = 0: no state change, including mid-packet gaps of any length.
- Reset mid-packet: the partial CRC is discarded and any pending result is dropped. The next beat after reset starts a new packet from INIT.
- Width rule: all CRC arithmetic is CRC_W bits; POLY, INIT and XOR_OUT are truncated to CRC_W bits.

Decomposition:
- Package crc_pkg:
  - function crc_step(crc, data, poly), parametrised via a localparam width or a parametrised class static function.
  - function bit_rev.
  - Preset constants: CRC16_CCITT_FALSE, CRC32_ETH, CRC5_USB.
  - mode_e enum {GEN, CHECK}.
- One natural sub-module: crc_out_reg, the 1-entry valid/ready holding register for {out_crc, out_err}.
- The companion interface is extended with a DRIVER clocking block (in_*, mode_check, exp_crc) and a MONITOR clocking block (all signals), plus out_ready.

Test Plan:
1. Defaults, GEN mode, ASCII "123456789" as 9 beats, last on '9', out_ready = 1 -> single result out_crc = 16'h29B1, out_err = 0.
2. Defaults, single beat 8'h00 with in_last = 1 -> out_crc = 16'hE1F0, out_valid asserted for exactly one cycle.
3. CRC_W = 32, POLY = 32'h04C11DB7, INIT = XOR_OUT = 32'hFFFFFFFF, REFLECT_IN = REFLECT_OUT = 1, "123456789" -> out_crc = 32'hCBF43926.
4. Defaults, CHECK mode, "123456789" with exp_crc = 16'h29B1 then 16'h29B0 -> out_err = 0 then out_err = 1.
5. Two packets back-to-back with out_ready = 0 for 5 cycles after the first result -> in_ready = 0 while held; first result stable; second result correct; no beat lost.
6. Assert rst after 4 beats of "123456789", then send the full string -> out_crc = 16'h29B1 with no residue from the aborted packet.
